pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program counter for the SAP CPU control path. It supports sequential count, absolute and PC-relative branches, and subroutine CALL/RET through an internal return-address stack. All state advances only on cycles where SLOW_CLOCK_STRB is asserted. It replaces the fixed 8-bit counter in the fetch stage and feeds PC_VAL to the memory address register.

Parameters:
ADDR_WIDTH, 8, width of PC_VAL, BRANCH_ADDRESS and BRANCH_OFFSET.
STACK_DEPTH, 4, number of return-address entries (legal range 1..16).
RESET_VECTOR, 0, value loaded into PC_VAL on reset.

Ports:
CLK  in  1  system clock; all state changes on its rising edge.
ACLR  in  1  asynchronous active-high reset.
SLOW_CLOCK_STRB  in  1  step enable; a command is acted on only in a cycle where this is 1.
PC_COUNT  in  1  increment PC.
BRANCH  in  1  load BRANCH_ADDRESS.
BRANCH_REL  in  1  add signed BRANCH_OFFSET to PC.
CALL  in  1  push return address, then load BRANCH_ADDRESS.
RET  in  1  pop return address into PC.
BRANCH_ADDRESS  in  ADDR_WIDTH  absolute target.
BRANCH_OFFSET  in  ADDR_WIDTH  two's-complement relative offset.
PC_VAL  out  ADDR_WIDTH  current program counter (registered).
STACK_LEVEL  out  5  number of valid stack entries, 0..STACK_DEPTH.
STACK_FULL  out  1  STACK_LEVEL == STACK_DEPTH (combinational from the level register).
STACK_EMPTY  out  1  STACK_LEVEL == 0.
STACK_OVF  out  1  sticky overflow flag: CALL issued while full.
STACK_UNF  out  1  sticky underflow flag: RET issued while empty.

Behaviour:
- Reset (ACLR=1, asynchronous, overrides everything): PC_VAL=RESET_VECTOR, STACK_LEVEL=0, STACK_OVF=0, STACK_UNF=0. Stack entry contents are don't-care and need not be reset. Reset asserted mid-sequence discards all pending state.
- Cycles with SLOW_CLOCK_STRB=0: no state changes, whatever the command inputs are.
- Cycles with SLOW_CLOCK_STRB=1: exactly one command is executed, chosen by fixed priority RET > CALL > BRANCH > BRANCH_REL > PC_COUNT. Lower-priority commands asserted in the same cycle are ignored, not queued. With no command asserted, PC holds.
- PC_COUNT: PC <= PC+1 modulo 2^ADDR_WIDTH. The maximum value wraps to 0 with no flag.
- BRANCH: PC <= BRANCH_ADDRESS.
- BRANCH_REL: PC <= PC + sign-extended BRANCH_OFFSET, modulo 2^ADDR_WIDTH. The target is relative to the current PC, not PC+1.
- CALL when not full:
  - stack[STACK_LEVEL] <= PC+1 (mod), STACK_LEVEL += 1, PC <= BRANCH_ADDRESS.
- CALL when full:
  - PC, stack and level are unchanged; STACK_OVF <= 1.
- RET when not empty:
  - PC <= stack[STACK_LEVEL-1], STACK_LEVEL -= 1.
- RET when empty:
  - PC and level are unchanged; STACK_UNF <= 1.
- STACK_OVF and STACK_UNF are cleared only by reset.
- Latency: every command takes effect one clock edge after the strobed cycle. PC_VAL and the stack outputs are registered, and no input-to-output combinational path exists.
- The stack is LIFO, indexed by the level register; there is no pointer wrap.
- Back-to-back strobed CALL then RET returns PC to the value CALL pushed.

Test Plan:
1. Reset, then 3 strobed PC_COUNT cycles -> PC_VAL 0,1,2,3. PC_COUNT=1 with SLOW_CLOCK_STRB=0 for 5 cycles -> PC_VAL stays 3.
2. PC=0xFF, strobed PC_COUNT -> PC_VAL=0x00, no flag set. PC=0x10, BRANCH_REL with offset 0xFC -> PC_VAL=0x0C. PC=0xFE, offset 0x05 -> PC_VAL=0x03.
3. PC=0x20, CALL to 0x80 -> PC_VAL=0x80, STACK_LEVEL=1. Then 2 counts, then RET -> PC_VAL=0x21, STACK_LEVEL=0, STACK_EMPTY=1.
4. Four nested CALLs from PCs 0x00, 0x40, 0x50, 0x60 -> STACK_FULL=1. A fifth CALL to 0x90 -> PC unchanged, STACK_OVF=1. Four RETs -> PC_VAL 0x61, 0x51, 0x41, 0x01. A fifth RET -> PC unchanged, STACK_UNF=1. Both flags stay 1 until ACLR.
5. PC=0x30 with RET, CALL, BRANCH and PC_COUNT all asserted and stack level 1 (top entry 0x11) -> PC_VAL=0x11, level 0. Same cycle with stack empty -> STACK_UNF=1, PC_VAL=0x30 (CALL is not executed).
6. Assert ACLR asynchronously between clock edges during a CALL sequence -> PC_VAL=RESET_VECTOR immediately, STACK_LEVEL=0, flags 0. Repeat with ADDR_WIDTH=12, STACK_DEPTH=8, RESET_VECTOR=0x100 -> PC_VAL=0x100, and wrap occurs at 0xFFF.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter with count, absolute/relative branch and CALL/RET via a return-address stack.
// All state advances only on strobed cycles; command priority is RET > CALL > BRANCH > REL > COUNT.
module pc_sequencer #(
    parameter int unsigned           ADDR_WIDTH   = 8,
    parameter int unsigned           STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  CLK,
    input  logic                  ACLR,
    input  logic                  SLOW_CLOCK_STRB,
    input  logic                  PC_COUNT,
    input  logic                  BRANCH,
    input  logic                  BRANCH_REL,
    input  logic                  CALL,
    input  logic                  RET,
    input  logic [ADDR_WIDTH-1:0] BRANCH_ADDRESS,
    input  logic [ADDR_WIDTH-1:0] BRANCH_OFFSET,
    output logic [ADDR_WIDTH-1:0] PC_VAL,
    output logic [4:0]            STACK_LEVEL,
    output logic                  STACK_FULL,
    output logic                  STACK_EMPTY,
    output logic                  STACK_OVF,
    output logic                  STACK_UNF
);

    localparam int unsigned IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_LVL = 5'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [4:0]            r_level;
    logic [4:0]            w_level_next;
    logic [4:0]            w_level_m1;
    logic                  r_ovf;
    logic                  w_ovf_next;
    logic                  r_unf;
    logic                  w_unf_next;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

    assign w_full     = (r_level == DEPTH_LVL);
    assign w_empty    = (r_level == 5'd0);
    assign w_pc_inc   = r_pc + ADDR_WIDTH'(1);
    assign w_level_m1 = r_level - 5'd1;
    assign w_wr_idx   = r_level[IDX_W-1:0];
    assign w_rd_idx   = w_level_m1[IDX_W-1:0];

    always_comb begin
        w_pc_next    = r_pc;
        w_level_next = r_level;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_push       = 1'b0;
        if (SLOW_CLOCK_STRB) begin
            if (RET) begin
                if (w_empty) begin
                    w_unf_next = 1'b1;
                end else begin
                    w_pc_next    = r_stack[w_rd_idx];
                    w_level_next = w_level_m1;
                end
            end else if (CALL) begin
                if (w_full) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_push       = 1'b1;
                    w_pc_next    = BRANCH_ADDRESS;
                    w_level_next = r_level + 5'd1;
                end
            end else if (BRANCH) begin
                w_pc_next = BRANCH_ADDRESS;
            end else if (BRANCH_REL) begin
                // Same-width add: modulo arithmetic gives the signed offset for free.
                w_pc_next = r_pc + BRANCH_OFFSET;
            end else if (PC_COUNT) begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            r_pc    <= RESET_VECTOR;
            r_level <= 5'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_level <= w_level_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // Stack contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign PC_VAL      = r_pc;
    assign STACK_LEVEL = r_level;
    assign STACK_FULL  = w_full;
    assign STACK_EMPTY = w_empty;
    assign STACK_OVF   = r_ovf;
    assign STACK_UNF   = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default 8-bit/depth-4 instance plus a 12-bit/depth-8 instance.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        ACLR;
    logic        STRB;
    logic        CNT, BR, REL, CALLC, RETC;
    logic [7:0]  addr8, off8;
    logic [11:0] addr12, off12;

    logic [7:0]  pc8;
    logic [4:0]  lvl8;
    logic        full8, empty8, ovf8, unf8;
    logic [11:0] pc12;
    logic [4:0]  lvl12;
    logic        full12, empty12, ovf12, unf12;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pc_sequencer dut8 (
        .CLK(CLK), .ACLR(ACLR), .SLOW_CLOCK_STRB(STRB), .PC_COUNT(CNT), .BRANCH(BR),
        .BRANCH_REL(REL), .CALL(CALLC), .RET(RETC), .BRANCH_ADDRESS(addr8),
        .BRANCH_OFFSET(off8), .PC_VAL(pc8), .STACK_LEVEL(lvl8), .STACK_FULL(full8),
        .STACK_EMPTY(empty8), .STACK_OVF(ovf8), .STACK_UNF(unf8)
    );

    pc_sequencer #(.ADDR_WIDTH(12), .STACK_DEPTH(8), .RESET_VECTOR(12'h100)) dut12 (
        .CLK(CLK), .ACLR(ACLR), .SLOW_CLOCK_STRB(STRB), .PC_COUNT(CNT), .BRANCH(BR),
        .BRANCH_REL(REL), .CALL(CALLC), .RET(RETC), .BRANCH_ADDRESS(addr12),
        .BRANCH_OFFSET(off12), .PC_VAL(pc12), .STACK_LEVEL(lvl12), .STACK_FULL(full12),
        .STACK_EMPTY(empty12), .STACK_OVF(ovf12), .STACK_UNF(unf12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        STRB = 1'b0; CNT = 1'b0; BR = 1'b0; REL = 1'b0; CALLC = 1'b0; RETC = 1'b0;
        addr8 = '0; off8 = '0; addr12 = '0; off12 = '0;
    endtask

    // One strobed cycle: command bits {ret,call,br,rel,cnt}; returns #1 after the edge.
    task automatic step(input logic [4:0] cmd, input logic [11:0] a, input logic [11:0] o);
        {RETC, CALLC, BR, REL, CNT} = cmd;
        addr8 = a[7:0]; off8 = o[7:0]; addr12 = a; off12 = o;
        STRB = 1'b1;
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        ACLR = 1'b1;
        @(posedge CLK);
        #1;
        ACLR = 1'b0;
    endtask

    localparam logic [4:0] C_RET = 5'b10000;
    localparam logic [4:0] C_CALL = 5'b01000;
    localparam logic [4:0] C_BR = 5'b00100;
    localparam logic [4:0] C_REL = 5'b00010;
    localparam logic [4:0] C_CNT = 5'b00001;

    initial begin
        idle_inputs();
        do_reset();
        chk("rst_pc", pc8, 8'h00);
        chk("rst_lvl", lvl8, 0);
        chk("rst_empty", empty8, 1);
        chk("rst_full", full8, 0);
        chk("rst_flags", {ovf8, unf8}, 2'b00);
        chk("rst_pc12", pc12, 12'h100);

        // Sequential count and strobe gating
        step(C_CNT, 0, 0); chk("cnt1", pc8, 1);
        step(C_CNT, 0, 0); chk("cnt2", pc8, 2);
        step(C_CNT, 0, 0); chk("cnt3", pc8, 3);
        CNT = 1'b1; CALLC = 1'b1; addr8 = 8'h55;
        repeat (5) @(posedge CLK);
        #1;
        idle_inputs();
        chk("nostrb_pc", pc8, 3);
        chk("nostrb_lvl", lvl8, 0);

        // Wrap and relative branches
        step(C_BR, 12'h0FF, 0); chk("br_ff", pc8, 8'hFF);
        step(C_CNT, 0, 0);      chk("wrap", pc8, 8'h00);
        chk("wrap_flags", {ovf8, unf8}, 2'b00);
        step(C_BR, 12'h010, 0); step(C_REL, 0, 12'h0FC); chk("rel_neg", pc8, 8'h0C);
        step(C_BR, 12'h0FE, 0); step(C_REL, 0, 12'h005); chk("rel_wrap", pc8, 8'h03);

        // Single CALL/RET
        step(C_BR, 12'h020, 0);
        step(C_CALL, 12'h080, 0); chk("call_pc", pc8, 8'h80); chk("call_lvl", lvl8, 1);
        step(C_CNT, 0, 0); step(C_CNT, 0, 0); chk("sub_cnt", pc8, 8'h82);
        step(C_RET, 0, 0);
        chk("ret_pc", pc8, 8'h21); chk("ret_lvl", lvl8, 0); chk("ret_empty", empty8, 1);

        // Nested calls, overflow, underflow
        step(C_BR, 12'h000, 0);
        step(C_CALL, 12'h040, 0);
        step(C_CALL, 12'h050, 0);
        step(C_CALL, 12'h060, 0);
        step(C_CALL, 12'h070, 0);
        chk("nest_full", full8, 1); chk("nest_lvl", lvl8, 4); chk("nest_pc", pc8, 8'h70);
        chk("nest_ovf0", ovf8, 0);
        step(C_CALL, 12'h090, 0);
        chk("ovf_pc", pc8, 8'h70); chk("ovf_flag", ovf8, 1); chk("ovf_lvl", lvl8, 4);
        step(C_RET, 0, 0); chk("pop1", pc8, 8'h61);
        step(C_RET, 0, 0); chk("pop2", pc8, 8'h51);
        step(C_RET, 0, 0); chk("pop3", pc8, 8'h41);
        step(C_RET, 0, 0); chk("pop4", pc8, 8'h01); chk("pop_lvl", lvl8, 0);
        chk("unf0", unf8, 0);
        step(C_RET, 0, 0);
        chk("unf_pc", pc8, 8'h01); chk("unf_flag", unf8, 1); chk("unf_lvl", lvl8, 0);
        step(C_CNT, 0, 0); step(C_BR, 12'h0AA, 0);
        chk("sticky", {ovf8, unf8}, 2'b11);

        // Priority
        do_reset();
        step(C_BR, 12'h010, 0);
        step(C_CALL, 12'h077, 0);
        step(C_BR, 12'h030, 0);
        step(C_RET | C_CALL | C_BR | C_CNT, 12'h099, 0);
        chk("prio_pc", pc8, 8'h11); chk("prio_lvl", lvl8, 0);
        step(C_BR, 12'h030, 0);
        step(C_RET | C_CALL | C_BR | C_CNT, 12'h099, 0);
        chk("prio_e_pc", pc8, 8'h30); chk("prio_e_unf", unf8, 1);
        chk("prio_e_lvl", lvl8, 0); chk("prio_e_ovf", ovf8, 0);

        // Asynchronous reset mid-sequence
        do_reset();
        step(C_RET, 0, 0);
        repeat (5) step(C_CALL, 12'h055, 0);
        chk("pre_ar_ovf", ovf8, 1); chk("pre_ar_lvl12", lvl12, 5);
        CALLC = 1'b1; STRB = 1'b1; addr8 = 8'h66; addr12 = 12'h666;
        #2;
        ACLR = 1'b1;
        #1;
        chk("ar_pc", pc8, 8'h00); chk("ar_lvl", lvl8, 0);
        chk("ar_flags", {ovf8, unf8}, 2'b00);
        chk("ar_pc12", pc12, 12'h100); chk("ar_lvl12", lvl12, 0);
        @(posedge CLK);
        #1;
        chk("ar_hold", pc8, 8'h00);
        idle_inputs();
        ACLR = 1'b0;

        // 12-bit instance
        step(C_CNT, 0, 0);        chk("w12_cnt", pc12, 12'h101);
        step(C_BR, 12'hFFF, 0);   chk("w12_br", pc12, 12'hFFF);
        step(C_CNT, 0, 0);        chk("w12_wrap", pc12, 12'h000);
        step(C_BR, 12'h005, 0);
        step(C_REL, 0, 12'hFFE);  chk("w12_rel", pc12, 12'h003);
        step(C_CALL, 12'hABC, 0); chk("w12_call", pc12, 12'hABC);
        step(C_RET, 0, 0);        chk("w12_ret", pc12, 12'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
